// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results to writeback, or runs one
// data-memory transaction (with timeout) for loads and stores.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   in_valid .. dst_addr
//                     execute-stage result and control
//   stall             high while a memory transaction is outstanding
//   dmem_*            data-memory request/response
//   wb_*              registered writeback bundle
//   err               one-cycle pulse on a faulted or timed-out access
module mem_stage #(
   parameter int MEM_AW  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              mem_to_reg,
   input  logic              reg_write,
   input  logic [31:0]       alu,
   input  logic [31:0]       rt,
   input  logic [4:0]        dst_addr,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [MEM_AW-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_ack,
   input  logic [31:0]       dmem_rdata,
   output logic              wb_valid,
   output logic              wb_reg_write,
   output logic [4:0]        wb_dst_addr,
   output logic [31:0]       wb_data,
   output logic              err
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [7:0] LIMIT = 8'(TIMEOUT);

   state_t            state;
   logic [7:0]        cnt;
   logic [MEM_AW-1:0] c_addr;
   logic [31:0]       c_wdata;
   logic              c_we;
   logic [4:0]        c_dst;
   logic              c_rw;
   logic              c_m2r;

   logic op_mem;
   logic op_bad;
   logic addr_hi;

   // Any address bit above the memory's word-address range is a fault.
   assign addr_hi = (alu >> MEM_AW) != 32'd0;
   assign op_mem  = mem_read | mem_write;
   assign op_bad  = (mem_read & mem_write) | addr_hi;

   assign stall      = (state == BUSY);
   assign dmem_req   = (state == BUSY);
   assign dmem_we    = c_we;
   assign dmem_addr  = c_addr;
   assign dmem_wdata = c_wdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         c_addr       <= '0;
         c_wdata      <= '0;
         c_we         <= 1'b0;
         c_dst        <= '0;
         c_rw         <= 1'b0;
         c_m2r        <= 1'b0;
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
         wb_dst_addr  <= '0;
         wb_data      <= '0;
         err          <= 1'b0;
      end else begin
         err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!in_valid) begin
                  wb_valid     <= 1'b0;
                  wb_reg_write <= 1'b0;
               end else if (!op_mem) begin
                  wb_valid     <= 1'b1;
                  wb_reg_write <= reg_write;
                  wb_dst_addr  <= dst_addr;
                  wb_data      <= alu;
               end else if (op_bad) begin
                  err          <= 1'b1;
                  wb_valid     <= 1'b1;
                  wb_reg_write <= 1'b0;
               end else begin
                  state        <= BUSY;
                  cnt          <= '0;
                  c_addr       <= alu[MEM_AW-1:0];
                  c_wdata      <= rt;
                  c_we         <= mem_write;
                  c_dst        <= dst_addr;
                  c_rw         <= reg_write;
                  c_m2r        <= mem_to_reg;
                  wb_valid     <= 1'b0;
                  wb_reg_write <= 1'b0;
               end
            end
            BUSY: begin
               // An ack on the limit cycle still counts as completion.
               if (dmem_ack) begin
                  state       <= IDLE;
                  wb_valid    <= 1'b1;
                  wb_dst_addr <= c_dst;
                  if (c_we) begin
                     wb_reg_write <= 1'b0;
                  end else begin
                     wb_reg_write <= c_rw;
                     wb_data      <= c_m2r ? dmem_rdata : 32'(c_addr);
                  end
               end else if (cnt == LIMIT) begin
                  state        <= IDLE;
                  err          <= 1'b1;
                  wb_valid     <= 1'b1;
                  wb_reg_write <= 1'b0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Randomised and directed bench for mem_stage against a transaction-level
// reference model.
module tb_mem_stage;

   localparam int AW = 16;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, mem_read, mem_write, mem_to_reg, reg_write;
   logic [31:0]   alu, rt;
   logic [4:0]    dst_addr;
   logic          stall, dmem_req, dmem_we;
   logic [AW-1:0] dmem_addr;
   logic [31:0]   dmem_wdata;
   logic          dmem_ack;
   logic [31:0]   dmem_rdata;
   logic          wb_valid, wb_reg_write;
   logic [4:0]    wb_dst_addr;
   logic [31:0]   wb_data;
   logic          err;

   mem_stage #(.MEM_AW(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .mem_read(mem_read), .mem_write(mem_write),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu(alu), .rt(rt), .dst_addr(dst_addr),
      .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
      .wb_dst_addr(wb_dst_addr), .wb_data(wb_data), .err(err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: one outstanding transaction, counted in busy cycles.
   bit          m_busy;
   int          m_n;
   logic [31:0] m_addr, m_wdata;
   logic        m_we, m_rw, m_m2r;
   logic [4:0]  m_dst;
   logic        e_wbv, e_wbrw, e_err;
   logic [4:0]  e_dst;
   logic [31:0] e_data;

   function automatic void model_reset();
      m_busy = 0; m_n = 0;
      m_addr = 0; m_wdata = 0; m_we = 0; m_rw = 0; m_m2r = 0; m_dst = 0;
      e_wbv = 0; e_wbrw = 0; e_err = 0; e_dst = 0; e_data = 0;
   endfunction

   function automatic void model_step();
      e_err = 0;
      if (!m_busy) begin
         if (!in_valid) begin
            e_wbv = 0; e_wbrw = 0;
         end else if (!mem_read && !mem_write) begin
            e_wbv = 1; e_wbrw = reg_write; e_dst = dst_addr; e_data = alu;
         end else if ((mem_read && mem_write) || alu >= (32'd1 << AW)) begin
            e_err = 1; e_wbv = 1; e_wbrw = 0;
         end else begin
            m_busy = 1; m_n = 0;
            m_addr = alu; m_wdata = rt; m_we = mem_write;
            m_dst = dst_addr; m_rw = reg_write; m_m2r = mem_to_reg;
            e_wbv = 0; e_wbrw = 0;
         end
      end else begin
         m_n++;
         e_wbv = 0; e_wbrw = 0;
         if (dmem_ack) begin
            m_busy = 0; e_wbv = 1; e_dst = m_dst;
            if (!m_we) begin
               e_wbrw = m_rw;
               e_data = m_m2r ? dmem_rdata : m_addr;
            end
         end else if (m_n == TO + 1) begin
            m_busy = 0; e_err = 1; e_wbv = 1;
         end
      end
   endfunction

   task automatic check_all();
      check("stall", stall, m_busy);
      check("dmem_req", dmem_req, m_busy);
      check("dmem_addr", dmem_addr, m_addr);
      check("dmem_we", dmem_we, m_we);
      check("dmem_wdata", dmem_wdata, m_wdata);
      check("wb_valid", wb_valid, e_wbv);
      check("wb_reg_write", wb_reg_write, e_wbrw);
      check("wb_dst_addr", wb_dst_addr, e_dst);
      check("wb_data", wb_data, e_data);
      check("err", err, e_err);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic drive(logic v, logic rd, logic wr, logic m2r, logic rw,
                        logic [31:0] a, logic [31:0] d, logic [4:0] dst);
      in_valid = v; mem_read = rd; mem_write = wr;
      mem_to_reg = m2r; reg_write = rw;
      alu = a; rt = d; dst_addr = dst;
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      dmem_ack = 0; dmem_rdata = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;

      // ALU op
      drive(1, 0, 0, 0, 1, 32'h2A, 0, 5'd5);
      tick();
      check("alu_wb_data", wb_data, 32'h2A);
      check("alu_wb_dst", wb_dst_addr, 32'd5);

      // Load, ack on the third busy cycle
      drive(1, 1, 0, 1, 1, 32'h10, 0, 5'd8);
      tick();
      check("ld_addr", dmem_addr, 32'h10);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
      tick();
      check("ld_wb_data", wb_data, 32'hDEAD_BEEF);
      check("ld_wb_dst", wb_dst_addr, 32'd8);
      dmem_ack = 0;

      // Store acked at once; an ALU op held upstream meanwhile
      drive(1, 0, 1, 0, 1, 32'h4, 32'h1234_5678, 5'd2);
      tick();
      check("st_we", dmem_we, 1);
      check("st_wdata", dmem_wdata, 32'h1234_5678);
      dmem_ack = 1;
      drive(1, 0, 0, 0, 1, 32'h7, 0, 5'd3);
      tick();
      check("st_wb_rw", wb_reg_write, 0);
      dmem_ack = 0;
      tick();
      check("after_st_data", wb_data, 32'h7);

      // Timeout: 16 busy cycles without ack
      drive(1, 1, 0, 1, 1, 32'h20, 0, 5'd9);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < TO + 1; i++) tick();
      check("to_err", err, 1);
      check("to_stall", stall, 0);
      tick();
      check("to_err_clr", err, 0);

      // Ack on the limit cycle wins
      drive(1, 1, 0, 1, 1, 32'h21, 0, 5'd10);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < TO; i++) tick();
      dmem_ack = 1; dmem_rdata = 32'hCAFE_0001;
      tick();
      check("lim_err", err, 0);
      check("lim_data", wb_data, 32'hCAFE_0001);
      dmem_ack = 0;

      // Faults
      drive(1, 1, 0, 1, 1, 32'h0001_0000, 0, 5'd4);
      tick();
      check("f_hi_err", err, 1);
      check("f_hi_req", dmem_req, 0);
      drive(1, 1, 1, 1, 1, 32'h20, 0, 5'd4);
      tick();
      check("f_rw_err", err, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      // Async reset during the second busy cycle
      drive(1, 1, 0, 1, 1, 32'h30, 0, 5'd6);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      #2 rst = 1'b1;
      model_reset();
      #1;
      check("rst_req", dmem_req, 0);
      check_all();
      #1 rst = 1'b0;
      dmem_ack = 1; dmem_rdata = 32'h5555_AAAA;
      tick();
      check("rst_no_wb", wb_valid, 0);
      dmem_ack = 0;

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         int unsigned k;
         k = $urandom_range(0, 9);
         in_valid   = ($urandom_range(0, 3) != 0);
         mem_read   = (k inside {[3:6]}) || k == 9;
         mem_write  = (k inside {[7:9]});
         mem_to_reg = $urandom_range(0, 1);
         reg_write  = $urandom_range(0, 1);
         alu        = ($urandom_range(0, 15) == 0) ? $urandom
                                                   : ($urandom & 32'hFFFF);
         rt         = $urandom;
         dst_addr   = 5'($urandom);
         dmem_ack   = ($urandom_range(0, 2) == 0);
         dmem_rdata = $urandom;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
